// File: rtl/irq_arbiter_pkg.sv
// Shared definitions for the interrupt arbiter: FSM state encodings and
// word-register offsets decoded from Addr[4:2].
package irq_arbiter_pkg;

  typedef enum logic [1:0] {
    IRQ_IDLE   = 2'd0,
    IRQ_ASSERT = 2'd1,
    IRQ_INSERV = 2'd2
  } irq_state_e;

  localparam logic [2:0] REG_MASK = 3'd0;
  localparam logic [2:0] REG_PEND = 3'd1;
  localparam logic [2:0] REG_CUR  = 3'd2;
  localparam logic [2:0] REG_EOI  = 3'd3;
  localparam logic [2:0] REG_STAT = 3'd4;

  // Builds the CUR register word: valid flag at bit 31, id in the low bits.
  function automatic logic [31:0] cur_word(input logic valid, input logic [7:0] id);
    return valid ? {1'b1, 23'd0, id} : 32'd0;
  endfunction

endpackage

// File: rtl/irq_arbiter_prio_enc.sv
// Combinational lowest-index-wins priority encoder (index 0 = highest priority).
module irq_prio_enc #(
  parameter int N_SRC = 6,
  parameter int ID_W  = 3
) (
  input  logic [N_SRC-1:0] req_i,
  output logic [ID_W-1:0]  id_o,
  output logic             valid_o
);

  // Scan from the top down so the lowest set index is the last one written.
  always_comb begin
    id_o    = '0;
    valid_o = |req_i;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (req_i[i]) id_o = ID_W'(i);
    end
  end

endmodule

// File: rtl/irq_arbiter.sv
// Memory-mapped interrupt arbiter: edge capture, mask, fixed priority and a
// req/ack/EOI handshake to CP0. Optional STAT ack counter under IRQ_STATS_EN.
module irq_arbiter
  import irq_arbiter_pkg::*;
#(
  parameter int N_SRC = 6,
  parameter int ID_W  = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_SRC-1:0] src_irq,
  input  logic [31:0]      Addr,
  input  logic             WE,
  input  logic [31:0]      Din,
  output logic [31:0]      Dout,
  output logic             irq_req,
  output logic [ID_W-1:0]  irq_id,
  input  logic             irq_ack
);

  irq_state_e       state_q;
  logic [N_SRC-1:0] src_q;
  logic [N_SRC-1:0] pend_q, pend_d;
  logic [N_SRC-1:0] mask_q, mask_d;
  logic             req_q;
  logic [ID_W-1:0]  id_q;
  logic             cur_valid_q;

  logic [N_SRC-1:0] cand;
  logic [N_SRC-1:0] sel_1h;
  logic [N_SRC-1:0] clr_bits;
  logic [ID_W-1:0]  win_id;
  logic             win_valid;
  logic [2:0]       reg_sel;
  logic             wr_mask, wr_pend, wr_eoi;
  logic             ack_acc;
  logic [31:0]      stat_rd;

  logic unused_bits;
  assign unused_bits = ^{Addr[31:5], Addr[1:0], Din[31:N_SRC]};

  assign reg_sel = Addr[4:2];
  assign wr_mask = WE && (reg_sel == REG_MASK);
  assign wr_pend = WE && (reg_sel == REG_PEND);
  assign wr_eoi  = WE && (reg_sel == REG_EOI);

  assign cand    = pend_q & mask_q;
  assign sel_1h  = N_SRC'(1) << id_q;
  assign ack_acc = (state_q == IRQ_ASSERT) && irq_ack;

  irq_prio_enc #(
    .N_SRC (N_SRC),
    .ID_W  (ID_W)
  ) u_prio_enc (
    .req_i   (cand),
    .id_o    (win_id),
    .valid_o (win_valid)
  );

  // Clears are applied first so a same-cycle new edge always survives.
  always_comb begin
    clr_bits = '0;
    if (wr_pend) clr_bits = clr_bits | Din[N_SRC-1:0];
    if (ack_acc) clr_bits = clr_bits | sel_1h;
    pend_d = (pend_q & ~clr_bits) | (src_irq & ~src_q);
    mask_d = wr_mask ? Din[N_SRC-1:0] : mask_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      src_q  <= '0;
      pend_q <= '0;
      mask_q <= '0;
    end else begin
      src_q  <= src_irq;
      pend_q <= pend_d;
      mask_q <= mask_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IRQ_IDLE;
      req_q       <= 1'b0;
      id_q        <= '0;
      cur_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IRQ_IDLE: begin
          if (win_valid) begin
            id_q    <= win_id;
            req_q   <= 1'b1;
            state_q <= IRQ_ASSERT;
          end
        end
        IRQ_ASSERT: begin
          if (irq_ack) begin
            cur_valid_q <= 1'b1;
            req_q       <= 1'b0;
            state_q     <= IRQ_INSERV;
          end else if ((cand & sel_1h) == '0) begin
            req_q   <= 1'b0;
            state_q <= IRQ_IDLE;
          end
        end
        IRQ_INSERV: begin
          if (wr_eoi) begin
            cur_valid_q <= 1'b0;
            state_q     <= IRQ_IDLE;
          end
        end
        default: begin
          req_q   <= 1'b0;
          state_q <= IRQ_IDLE;
        end
      endcase
    end
  end

`ifdef IRQ_STATS_EN
  logic [31:0] stat_q;
  logic        wr_stat;
  assign wr_stat = WE && (reg_sel == REG_STAT);

  // Only assigned on an event; a clearing write beats a same-cycle ack.
  always_ff @(posedge clk) begin
    if (reset) begin
      stat_q <= '0;
    end else if (wr_stat) begin
      stat_q <= '0;
    end else if (ack_acc) begin
      stat_q <= stat_q + 32'd1;
    end
  end
  assign stat_rd = stat_q;
`else
  assign stat_rd = '0;
`endif

  always_comb begin
    Dout = '0;
    case (reg_sel)
      REG_MASK: Dout = 32'(mask_q);
      REG_PEND: Dout = 32'(pend_q);
      REG_CUR:  Dout = cur_word(cur_valid_q, 8'(id_q));
      REG_STAT: Dout = stat_rd;
      default:  Dout = '0;
    endcase
  end

  assign irq_req = req_q;
  assign irq_id  = id_q;

endmodule

// File: tb/tb_irq_arbiter.sv
// Self-checking bench for irq_arbiter: directed scenarios plus a random phase,
// all cycles compared against a behavioural model of pend/mask/handshake rules.
module tb_irq_arbiter;

  localparam int N = 6;

  logic        clk = 1'b0;
  logic        reset;
  logic [5:0]  src_irq;
  logic [31:0] Addr;
  logic        WE;
  logic [31:0] Din;
  logic [31:0] Dout;
  logic        irq_req;
  logic [2:0]  irq_id;
  logic        irq_ack;

  int checks = 0;
  int failures = 0;

  // Behavioural model: mode 0 = nothing requested, 1 = requesting, 2 = in service
  logic [5:0]  m_pend, m_mask, m_prev;
  int          m_mode;
  logic [2:0]  m_id;
  logic        m_cur;
  logic [31:0] m_stat;

  irq_arbiter #(.N_SRC(6), .ID_W(3)) dut (
    .clk     (clk),
    .reset   (reset),
    .src_irq (src_irq),
    .Addr    (Addr),
    .WE      (WE),
    .Din     (Din),
    .Dout    (Dout),
    .irq_req (irq_req),
    .irq_id  (irq_id),
    .irq_ack (irq_ack)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model_read(input logic [2:0] r);
    case (r)
      3'd0: return {26'd0, m_mask};
      3'd1: return {26'd0, m_pend};
      3'd2: return m_cur ? {1'b1, 28'd0, m_id} : 32'd0;
`ifdef IRQ_STATS_EN
      3'd4: return m_stat;
`endif
      default: return 32'd0;
    endcase
  endfunction

  function automatic void model_step();
    logic [5:0] rise, cand, clr;
    logic [2:0] r;
    logic       accepted;
    if (reset) begin
      m_pend = 0; m_mask = 0; m_prev = 0; m_mode = 0; m_id = 0; m_cur = 0; m_stat = 0;
      return;
    end
    r        = Addr[4:2];
    rise     = src_irq & ~m_prev;
    cand     = m_pend & m_mask;
    accepted = (m_mode == 1) && irq_ack;
    clr      = 0;
    if (WE && r == 3'd1) clr = clr | Din[5:0];
    if (accepted) clr[m_id] = 1'b1;
    if (m_mode == 0) begin
      for (int i = 0; i < N; i++) begin
        if (cand[i]) begin
          m_id = 3'(i);
          m_mode = 1;
          break;
        end
      end
    end else if (m_mode == 1) begin
      if (irq_ack) begin
        m_mode = 2;
        m_cur = 1'b1;
      end else if (!cand[m_id]) begin
        m_mode = 0;
      end
    end else if (WE && r == 3'd3) begin
      m_mode = 0;
      m_cur = 1'b0;
    end
    if (WE && r == 3'd0) m_mask = Din[5:0];
    m_pend = (m_pend & ~clr) | rise;
    m_prev = src_irq;
    if (WE && r == 3'd4) m_stat = 0;
    else if (accepted) m_stat = m_stat + 32'd1;
  endfunction

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check("model_req", {31'd0, irq_req}, {31'd0, m_mode == 1});
    if (m_mode != 0) check("model_id", {29'd0, irq_id}, {29'd0, m_id});
    check("model_dout", Dout, model_read(Addr[4:2]));
  endtask

  task automatic wr(input logic [2:0] r, input logic [31:0] d);
    Addr = {27'd0, r, 2'b00};
    Din  = d;
    WE   = 1'b1;
    $display("wr reg=%0d data=0x%08h", r, d);
    tick();
    WE  = 1'b0;
    Din = 32'd0;
  endtask

  task automatic rd(input logic [2:0] r, input string tag, input logic [31:0] exp);
    Addr = {27'd0, r, 2'b00};
    #1;
    check(tag, Dout, exp);
  endtask

  task automatic ack_once();
    irq_ack = 1'b1;
    tick();
    irq_ack = 1'b0;
  endtask

  initial begin
    reset = 1'b1; src_irq = '0; Addr = '0; WE = 1'b0; Din = '0; irq_ack = 1'b0;
    m_pend = 0; m_mask = 0; m_prev = 0; m_mode = 0; m_id = 0; m_cur = 0; m_stat = 0;
    repeat (3) tick();
    reset = 1'b0;
    rd(3'd0, "rst_mask", 32'd0);
    rd(3'd1, "rst_pend", 32'd0);
    rd(3'd2, "rst_cur", 32'd0);
    check("rst_req", {31'd0, irq_req}, 32'd0);

    // Basic request / ack / EOI with the 2-cycle latency
    wr(3'd0, 32'h3F);
    src_irq[2] = 1'b1;
    tick();
    check("s1_latency1", {31'd0, irq_req}, 32'd0);
    tick();
    check("s1_req", {31'd0, irq_req}, 32'd1);
    check("s1_id", {29'd0, irq_id}, 32'd2);
    ack_once();
    check("s1_req_drop", {31'd0, irq_req}, 32'd0);
    rd(3'd1, "s1_pend", 32'd0);
    rd(3'd2, "s1_cur", 32'h8000_0002);
    wr(3'd3, 32'h0);
    rd(3'd2, "s1_cur_eoi", 32'd0);
    src_irq = '0;
    tick();

    // Simultaneous sources: priority then next after EOI
    src_irq = 6'b010010;
    tick(); tick();
    check("s2_id_first", {29'd0, irq_id}, 32'd1);
    ack_once();
    wr(3'd3, 32'h0);
    tick();
    check("s2_req_second", {31'd0, irq_req}, 32'd1);
    check("s2_id_second", {29'd0, irq_id}, 32'd4);
    ack_once();
    wr(3'd3, 32'h0);
    src_irq = '0;
    tick();

    // Masked pending, then unmask
    wr(3'd0, 32'h0);
    src_irq[3] = 1'b1;
    tick(); tick();
    rd(3'd1, "s3_pend", 32'h08);
    check("s3_no_req", {31'd0, irq_req}, 32'd0);
    wr(3'd0, 32'h08);
    check("s3_req_wrcycle", {31'd0, irq_req}, 32'd0);
    tick();
    check("s3_req", {31'd1, irq_req} & 32'd1, 32'd1);
    check("s3_id", {29'd0, irq_id}, 32'd3);
    ack_once();
    wr(3'd3, 32'h0);
    src_irq = '0;
    tick();

    // Software withdraw via W1C, then W1C racing a new edge
    wr(3'd0, 32'h3F);
    src_irq[0] = 1'b1;
    tick(); tick();
    check("s4_req", {31'd0, irq_req}, 32'd1);
    wr(3'd1, 32'h01);
    check("s4_req_hold", {31'd0, irq_req}, 32'd1);
    tick();
    check("s4_withdraw", {31'd0, irq_req}, 32'd0);
    rd(3'd2, "s4_cur", 32'd0);
    src_irq[0] = 1'b0;
    tick();
    src_irq[0] = 1'b1;
    wr(3'd1, 32'h01);
    rd(3'd1, "s4_set_wins", 32'h01);
    tick();
    ack_once();
    wr(3'd3, 32'h0);
    src_irq = '0;
    tick();

    // Reset during service with a held source line
    src_irq[5] = 1'b1;
    tick(); tick();
    check("s5_id", {29'd0, irq_id}, 32'd5);
    ack_once();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("s5_rst_req", {31'd0, irq_req}, 32'd0);
    rd(3'd2, "s5_rst_cur", 32'd0);
    rd(3'd1, "s5_rst_pend", 32'd0);
    tick();
    rd(3'd1, "s5_held_edge", 32'h20);
    src_irq = '0;
    tick();

`ifdef IRQ_STATS_EN
    wr(3'd0, 32'h3F);
    wr(3'd4, 32'h0);
    for (int k = 0; k < 3; k++) begin
      src_irq[1] = 1'b1;
      tick(); tick();
      ack_once();
      wr(3'd3, 32'h0);
      src_irq = '0;
      tick();
    end
    rd(3'd4, "stat_three", 32'd3);
    wr(3'd4, 32'h1234);
    rd(3'd4, "stat_clear", 32'd0);
    force dut.stat_q = 32'hFFFF_FFFF;
    m_stat = 32'hFFFF_FFFF;
    src_irq[1] = 1'b1;
    tick(); tick();
    release dut.stat_q;
    ack_once();
    rd(3'd4, "stat_wrap", 32'd0);
    wr(3'd3, 32'h0);
    src_irq = '0;
    tick();
`endif

    // Random phase against the model
    for (int c = 0; c < 800; c++) begin
      if ($urandom_range(0, 3) == 0) src_irq[$urandom_range(0, 5)] ^= 1'b1;
      Addr    = $urandom();
      WE      = ($urandom_range(0, 5) == 0);
      Din     = $urandom();
      irq_ack = ($urandom_range(0, 3) == 0);
      reset   = ($urandom_range(0, 249) == 0);
      tick();
    end
    WE = 1'b0; irq_ack = 1'b0; reset = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
